// File: rtl/ppl_pkg.sv
// Shared definitions for the raster pixel scanner: state encoding, counter widths
// and the frame-size helper used for elaboration-time geometry checks.
package ppl_pkg;

    localparam int PPL_ADDR_W = 20;
    localparam int PPL_X_W    = 11;
    localparam int PPL_Y_W    = 10;

    typedef logic [1:0] ppl_state_t;

    localparam ppl_state_t PPL_ST_IDLE = 2'd0;
    localparam ppl_state_t PPL_ST_SCAN = 2'd1;
    localparam ppl_state_t PPL_ST_DONE = 2'd2;

    function automatic int unsigned ppl_frame_size(input int unsigned h_disp,
                                                   input int unsigned v_disp);
        return h_disp * v_disp;
    endfunction

endpackage

// File: rtl/ppl_ndc_map.sv
// Combinational centring of raster coordinates into signed, y-up screen space.
// Only instantiated when PPL_SCANNER_NDC_EN is defined; the output register lives in ppl_scanner.
module ppl_ndc_map
    import ppl_pkg::*;
#(
    parameter int H_DISP = 1280,
    parameter int V_DISP = 720
) (
    input  logic        [PPL_X_W-1:0] pix_x_i,
    input  logic        [PPL_Y_W-1:0] pix_y_i,
    output logic signed [PPL_X_W:0]   ndc_x_o,
    output logic signed [PPL_Y_W:0]   ndc_y_o
);

    localparam logic signed [PPL_X_W:0] HALF_H = (PPL_X_W + 1)'(H_DISP / 2);
    localparam logic signed [PPL_Y_W:0] HALF_V = (PPL_Y_W + 1)'(V_DISP / 2);

    // Zero-extend before the signed subtraction so large x/y never read as negative.
    assign ndc_x_o = $signed({1'b0, pix_x_i}) - HALF_H;
    assign ndc_y_o = HALF_V - $signed({1'b0, pix_y_i});

endmodule

// File: rtl/ppl_scanner.sv
// Raster pixel scanner: walks the display row-major, one pixel per enabled cycle.
// Optional feature macro PPL_SCANNER_NDC_EN adds registered centred coordinates ndc_x/ndc_y.
module ppl_scanner
    import ppl_pkg::*;
#(
    parameter int H_DISP = 1280,
    parameter int V_DISP = 720
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  prepare_flag,
    input  logic                  scanner_en,
    input  logic                  scanner_stop,
    output logic [PPL_ADDR_W-1:0] pixel_addr_out,
    output logic [PPL_X_W-1:0]    pix_x,
    output logic [PPL_Y_W-1:0]    pix_y,
    output logic                  pix_valid,
    output logic                  frame_first,
`ifdef PPL_SCANNER_NDC_EN
    output logic                  frame_last,
    output logic signed [PPL_X_W:0] ndc_x,
    output logic signed [PPL_Y_W:0] ndc_y
`else
    output logic                  frame_last
`endif
);

    localparam logic [PPL_ADDR_W-1:0] FRAME_SIZE = PPL_ADDR_W'(ppl_frame_size(H_DISP, V_DISP));
    localparam logic [PPL_X_W-1:0]    X_LAST     = PPL_X_W'(H_DISP - 1);
    localparam logic [PPL_Y_W-1:0]    Y_LAST     = PPL_Y_W'(V_DISP - 1);

    if (ppl_frame_size(H_DISP, V_DISP) >= (32'd1 << PPL_ADDR_W) ||
        H_DISP > 2048 || V_DISP > 1024) begin : g_cfg_err
        $error("ppl_scanner: unsupported display geometry %0d x %0d", H_DISP, V_DISP);
    end

    ppl_state_t            state_q, state_d;
    logic [PPL_X_W-1:0]    x_q, x_d;
    logic [PPL_Y_W-1:0]    y_q, y_d;
    logic [PPL_ADDR_W-1:0] addr_q, addr_d;
    logic                  emit;
    logic                  at_origin;
    logic                  at_last;

    logic [PPL_X_W-1:0]    pix_x_q;
    logic [PPL_Y_W-1:0]    pix_y_q;
    logic                  pix_valid_q;
    logic                  frame_first_q;
    logic                  frame_last_q;

    assign at_origin = (x_q == '0) && (y_q == '0);
    assign at_last   = (x_q == X_LAST) && (y_q == Y_LAST);

    // NOTE: every next-state signal gets a default first, so no path through the
    // case below can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        emit    = 1'b0;
        if (prepare_flag) begin
            state_d = PPL_ST_IDLE;
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
        end else begin
            case (state_q)
                PPL_ST_IDLE: begin
                    state_d = PPL_ST_SCAN;
                end
                PPL_ST_SCAN: begin
                    if (scanner_en && !scanner_stop) begin
                        emit = 1'b1;
                        if (at_last) begin
                            addr_d  = FRAME_SIZE;
                            state_d = PPL_ST_DONE;
                        end else begin
                            addr_d = addr_q + PPL_ADDR_W'(1);
                            if (x_q == X_LAST) begin
                                x_d = '0;
                                y_d = y_q + PPL_Y_W'(1);
                            end else begin
                                x_d = x_q + PPL_X_W'(1);
                            end
                        end
                    end
                end
                PPL_ST_DONE: begin
                    state_d = PPL_ST_DONE;
                end
                default: begin
                    state_d = PPL_ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= PPL_ST_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            addr_q        <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_valid_q   <= 1'b0;
            frame_first_q <= 1'b0;
            frame_last_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            addr_q        <= addr_d;
            pix_valid_q   <= emit;
            frame_first_q <= emit && at_origin;
            frame_last_q  <= emit && at_last;
            if (emit) begin
                pix_x_q <= x_q;
                pix_y_q <= y_q;
            end
        end
    end

    assign pixel_addr_out = addr_q;
    assign pix_x          = pix_x_q;
    assign pix_y          = pix_y_q;
    assign pix_valid      = pix_valid_q;
    assign frame_first    = frame_first_q;
    assign frame_last     = frame_last_q;

`ifdef PPL_SCANNER_NDC_EN
    logic signed [PPL_X_W:0] ndc_x_d, ndc_x_q;
    logic signed [PPL_Y_W:0] ndc_y_d, ndc_y_q;

    ppl_ndc_map #(
        .H_DISP (H_DISP),
        .V_DISP (V_DISP)
    ) u_ndc_map (
        .pix_x_i (x_q),
        .pix_y_i (y_q),
        .ndc_x_o (ndc_x_d),
        .ndc_y_o (ndc_y_d)
    );

    // Captured alongside pix_x/pix_y so the centred pair adds no latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ndc_x_q <= '0;
            ndc_y_q <= '0;
        end else if (emit) begin
            ndc_x_q <= ndc_x_d;
            ndc_y_q <= ndc_y_d;
        end
    end

    assign ndc_x = ndc_x_q;
    assign ndc_y = ndc_y_q;
`endif

endmodule

// File: doc/ppl_scanner.md
# ppl_scanner

Raster pixel scanner for the render pipeline. Walks the display in row-major order, one pixel per enabled cycle, and emits screen coordinates into the pipeline front end. Sits directly upstream of the pipeline controller: it consumes `prepare_flag`, `scanner_en` and `scanner_stop` from the controller and returns `pixel_addr_out`, which the controller uses to detect frame end.

## Interface

- `H_DISP`, 1280, active pixels per line.
- `V_DISP`, 720, active lines per frame.
- `clk`  input  1  pipeline clock.
- `rst`  input  1  reset, asynchronous, active-high.
- `prepare_flag`  input  1  controller is in its pre-frame window; scanner is held at origin.
- `scanner_en`  input  1  advance one pixel this cycle.
- `scanner_stop`  input  1  controller freeze request; blocks advancing.
- `pixel_addr_out`  output  20  linear address of the next pixel to emit; equals `H_DISP*V_DISP` once the frame is exhausted.
- `pix_x`  output  11  x of the emitted pixel.
- `pix_y`  output  10  y of the emitted pixel.
- `pix_valid`  output  1  `pix_x`/`pix_y` carry a new pixel this cycle.
- `frame_first`  output  1  emitted pixel is (0,0).
- `frame_last`  output  1  emitted pixel is (`H_DISP-1`,`V_DISP-1`).
- `ndc_x`  output  12 signed  centred x; present only with `PPL_SCANNER_NDC_EN`.
- `ndc_y`  output  11 signed  centred y; present only with `PPL_SCANNER_NDC_EN`.

## Operation

- States: IDLE, SCAN, DONE. Reset state is IDLE.
- IDLE:
  - Counters x, y and addr are held at 0.
  - Leaves to SCAN on the first cycle `prepare_flag` is low.
- SCAN, when `scanner_en && !scanner_stop`:
  - Emits the current (x,y): registered `pix_valid` = 1 with those coordinates.
  - Then advances: addr+1; x+1; at `x == H_DISP-1`, x wraps to 0 and y increments.
  - Emitting (`H_DISP-1`,`V_DISP-1`) sets addr = `H_DISP*V_DISP`, keeps x and y at their last values, and moves to DONE.
- SCAN, when `scanner_en` is low or `scanner_stop` is high: counters are frozen and `pix_valid` is 0.
- DONE:
  - addr is held at `H_DISP*V_DISP`.
  - `scanner_en` is ignored and no pixels are emitted.
  - Leaves to IDLE when `prepare_flag` rises; counters clear to 0.
- Priority: `rst` > `prepare_flag` > `scanner_stop` > `scanner_en`.
  - `prepare_flag` high in any state forces IDLE and clears the counters the next cycle.
  - This mid-frame abort drops the pixel in flight; `pix_valid` is 0 that cycle.
- `frame_first` and `frame_last` are asserted only together with `pix_valid`.
- Elaboration check: `H_DISP*V_DISP` must be < 2^20, `H_DISP` ≤ 2048 and `V_DISP` ≤ 1024; otherwise stop with `$error`.

## Timing

- All outputs are registered.
- Reset values: `pixel_addr_out` = 0, `pix_x` = 0, `pix_y` = 0, `pix_valid` = 0, `frame_first` = 0, `frame_last` = 0, `ndc_x` = 0, `ndc_y` = 0.
- Latency: `scanner_en` accepted at edge N → `pix_valid`/coords valid after edge N+1. `pixel_addr_out` updates at the same edge.
- Throughput: one pixel per cycle with `scanner_en` held high.
- Frame end: `pixel_addr_out == H_DISP*V_DISP` becomes visible in the same cycle as `frame_last`. The controller's `scanner_stop` is therefore at least one cycle late, which is harmless because DONE already ignores `scanner_en`.
- IDLE→SCAN: 1 cycle after `prepare_flag` falls. An enable in that same cycle is accepted and emits (0,0).

## Configuration

- `PPL_SCANNER_NDC_EN` defined:
  - `ndc_x = pix_x - H_DISP/2`, `ndc_y = V_DISP/2 - pix_y` (y up), in signed two's complement.
  - Registered in the same stage as `pix_x`, so there is no extra latency.
- Undefined: the `ndc_x`/`ndc_y` ports and their logic are absent. All other behaviour is identical.

## Structure

- Shared package `ppl_pkg`:
  - state encoding (IDLE=0, SCAN=1, DONE=2, 2 bits);
  - `PPL_ADDR_W=20`, `PPL_X_W=11`, `PPL_Y_W=10`;
  - the `H_DISP*V_DISP` frame-size function.
- Sub-module `ppl_ndc_map`: combinational centring/sign conversion, instantiated only under `PPL_SCANNER_NDC_EN`. The output register stays in `ppl_scanner`.

## Test plan

All scenarios use `H_DISP=8`, `V_DISP=4`.

- Reset mid-SCAN at addr 13 → all outputs 0 immediately (async); IDLE; after release and `prepare_flag` low, the first pixel is (0,0).
- `prepare_flag` low, `scanner_en` held high → 32 consecutive `pix_valid` pulses:
  - (0,0)…(7,0),(0,1)…(7,3);
  - `frame_first` on the first, `frame_last` on the 32nd;
  - `pixel_addr_out`=32 after; no further valid pulses.
- `scanner_en` toggled 1/0 and `scanner_stop` pulsed at addr 5 → emission count exactly equals accepted-enable count; the coordinate after the stall is (5,0).
- DONE with `scanner_en` high for 10 cycles → addr stays 32, `pix_valid`=0; `prepare_flag` rise → addr 0 next cycle.
- `prepare_flag` asserted at addr 20 with `scanner_en` high → no `pix_valid` that cycle; counters 0 the next cycle.
- `PPL_SCANNER_NDC_EN` build → pixel (0,0) gives `ndc_x`=-4, `ndc_y`=2; pixel (7,3) gives `ndc_x`=3, `ndc_y`=-1.
